// File: rtl/sr_latch_bank.sv
// Multi-channel clocked S-R bank with selectable S=R=1 behaviour, sticky conflict flags and a saturating conflict counter.
// Optional build macro SR_BANK_EDGE_EN: requests act only on their rising edge instead of their level.
module sr_latch_bank #(
  parameter int               WIDTH = 4,
  parameter int               MODE  = 1,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] conflict_flag,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] se;
  logic [WIDTH-1:0] re;
  logic [WIDTH-1:0] conflict;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] flag_next;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;

`ifdef SR_BANK_EDGE_EN
  // History clears on reset, so a request already high at reset release counts as an edge.
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] r_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_d <= '0;
      r_d <= '0;
    end else begin
      s_d <= s;
      r_d <= r;
    end
  end

  assign se = s & ~s_d;
  assign re = r & ~r_d;
`else
  assign se = s;
  assign re = r;
`endif

  assign conflict = se & re;

  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({se[i], re[i]})
        2'b10:   q_next[i] = 1'b1;
        2'b01:   q_next[i] = 1'b0;
        2'b11: begin
          if (MODE == 1)      q_next[i] = 1'b1;
          else if (MODE == 2) q_next[i] = 1'b0;
          else if (MODE == 3) q_next[i] = ~q[i];
          else                q_next[i] = q[i];
        end
        default: q_next[i] = q[i];
      endcase
    end
  end

  // A clear and a fresh conflict in the same cycle leave the conflict visible.
  always_comb begin
    flag_next = (conflict_clr ? '0 : conflict_flag) | conflict;
    cnt_base  = conflict_clr ? '0 : conflict_cnt;
    cnt_next  = cnt_base;
    if ((|conflict) && (cnt_base != CNT_MAX)) begin
      cnt_next = cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q             <= INIT;
      conflict_flag <= '0;
      conflict_cnt  <= '0;
    end else begin
      q             <= q_next;
      conflict_flag <= flag_next;
      conflict_cnt  <= cnt_next;
    end
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Self-checking bench: five sr_latch_bank instances (MODE 0..3, plus MODE 1 with INIT=4'hA) share one stimulus stream.
// A behavioural model pushes expected state into a scoreboard queue per step; each test task pops and compares.
module tb_sr_latch_bank;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] flag;
    logic [1:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] s = '0;
  logic [3:0] r = '0;
  logic       conflict_clr = 1'b0;

  logic [3:0] q_w[5];
  logic [3:0] qbar_w[5];
  logic [3:0] flag_w[5];
  logic [1:0] cnt_w[5];

  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];

  int         modes[5] = '{0, 1, 2, 3, 1};
  logic [3:0] inits[5] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hA};
  logic [3:0] mq[5];
  logic [3:0] mflag[5];
  logic [1:0] mcnt[5];
  logic [3:0] msd[5];
  logic [3:0] mrd[5];

  always #5 clk = ~clk;

  sr_latch_bank #(.WIDTH(4), .MODE(0), .INIT(4'h0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .s(s), .r(r), .conflict_clr(conflict_clr),
    .q(q_w[0]), .qbar(qbar_w[0]), .conflict_flag(flag_w[0]), .conflict_cnt(cnt_w[0]));
  sr_latch_bank #(.WIDTH(4), .MODE(1), .INIT(4'h0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .s(s), .r(r), .conflict_clr(conflict_clr),
    .q(q_w[1]), .qbar(qbar_w[1]), .conflict_flag(flag_w[1]), .conflict_cnt(cnt_w[1]));
  sr_latch_bank #(.WIDTH(4), .MODE(2), .INIT(4'h0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .s(s), .r(r), .conflict_clr(conflict_clr),
    .q(q_w[2]), .qbar(qbar_w[2]), .conflict_flag(flag_w[2]), .conflict_cnt(cnt_w[2]));
  sr_latch_bank #(.WIDTH(4), .MODE(3), .INIT(4'h0), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .s(s), .r(r), .conflict_clr(conflict_clr),
    .q(q_w[3]), .qbar(qbar_w[3]), .conflict_flag(flag_w[3]), .conflict_cnt(cnt_w[3]));
  sr_latch_bank #(.WIDTH(4), .MODE(1), .INIT(4'hA), .CNT_W(2)) dut4 (
    .clk(clk), .rst(rst), .s(s), .r(r), .conflict_clr(conflict_clr),
    .q(q_w[4]), .qbar(qbar_w[4]), .conflict_flag(flag_w[4]), .conflict_cnt(cnt_w[4]));

  // Drive one cycle of inputs, advance the model for every instance, and wait until the outputs settle.
  task automatic applyStimulus(input logic [3:0] sv, input logic [3:0] rv,
                               input logic clrv, input logic rstv);
    logic [3:0] se, re, nq, conf;
    logic [1:0] base;
    @(negedge clk);
    s = sv;
    r = rv;
    conflict_clr = clrv;
    rst = rstv;
    for (int k = 0; k < 5; k++) begin
      if (rstv) begin
        mq[k] = inits[k];
        mflag[k] = '0;
        mcnt[k] = '0;
        msd[k] = '0;
        mrd[k] = '0;
      end else begin
`ifdef SR_BANK_EDGE_EN
        se = sv & ~msd[k];
        re = rv & ~mrd[k];
`else
        se = sv;
        re = rv;
`endif
        nq = mq[k];
        for (int b = 0; b < 4; b++) begin
          if (se[b] && re[b]) begin
            case (modes[k])
              1: nq[b] = 1'b1;
              2: nq[b] = 1'b0;
              3: nq[b] = ~mq[k][b];
              default: nq[b] = mq[k][b];
            endcase
          end else if (se[b]) begin
            nq[b] = 1'b1;
          end else if (re[b]) begin
            nq[b] = 1'b0;
          end
        end
        conf = se & re;
        mflag[k] = (clrv ? 4'h0 : mflag[k]) | conf;
        base = clrv ? 2'd0 : mcnt[k];
        if ((conf != 4'h0) && (base != 2'd3)) base = base + 2'd1;
        mcnt[k] = base;
        msd[k] = sv;
        mrd[k] = rv;
        mq[k] = nq;
      end
      sb.push_back('{q: mq[k], flag: mflag[k], cnt: mcnt[k]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    applyStimulus(4'hF, 4'hF, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      e = sb.pop_front();
      checks++;
      if ({q_w[k], qbar_w[k], flag_w[k], cnt_w[k]} !== {e.q, ~e.q, e.flag, e.cnt}) begin
        errors++;
        $display("[TB] FAIL reset dut%0d: got q=%h qbar=%h flag=%h cnt=%0d, need q=%h qbar=%h flag=%h cnt=%0d",
                 k, q_w[k], qbar_w[k], flag_w[k], cnt_w[k], e.q, ~e.q, e.flag, e.cnt);
      end
    end
    checks++;
    if ({q_w[0], qbar_w[0], flag_w[0], cnt_w[0]} !== {4'h0, 4'hF, 4'h0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL reset_literal: got q=%h qbar=%h flag=%h cnt=%0d, need 0 F 0 0",
               q_w[0], qbar_w[0], flag_w[0], cnt_w[0]);
    end
  endtask

  task automatic test_set_reset();
    exp_t e;
    logic [3:0] sv[3] = '{4'b0101, 4'b0000, 4'b0000};
    logic [3:0] rv[3] = '{4'b0000, 4'b0000, 4'b0001};
    for (int t = 0; t < 3; t++) begin
      applyStimulus(sv[t], rv[t], 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
        e = sb.pop_front();
        checks++;
        if ({q_w[k], qbar_w[k], flag_w[k], cnt_w[k]} !== {e.q, ~e.q, e.flag, e.cnt}) begin
          errors++;
          $display("[TB] FAIL set_reset[%0d] dut%0d: got q=%h flag=%h cnt=%0d, need q=%h flag=%h cnt=%0d",
                   t, k, q_w[k], flag_w[k], cnt_w[k], e.q, e.flag, e.cnt);
        end
      end
    end
    checks++;
    if (q_w[1] !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL set_reset_literal: got q=%b, need 0100", q_w[1]);
    end
  endtask

  task automatic test_conflict_modes();
    exp_t e;
    logic want[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] sv[3] = '{4'b0001, 4'b0000, 4'b0001};
    logic [3:0] rv[3] = '{4'b0000, 4'b0000, 4'b0001};
    for (int t = 0; t < 3; t++) begin
      applyStimulus(sv[t], rv[t], 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
        e = sb.pop_front();
        checks++;
        if ({q_w[k], qbar_w[k], flag_w[k], cnt_w[k]} !== {e.q, ~e.q, e.flag, e.cnt}) begin
          errors++;
          $display("[TB] FAIL conflict_modes[%0d] dut%0d: got q=%h flag=%h cnt=%0d, need q=%h flag=%h cnt=%0d",
                   t, k, q_w[k], flag_w[k], cnt_w[k], e.q, e.flag, e.cnt);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({q_w[k][0], flag_w[k], cnt_w[k]} !== {want[k], 4'b0001, 2'd1}) begin
        errors++;
        $display("[TB] FAIL mode%0d_literal: got q0=%b flag=%b cnt=%0d, need q0=%b flag=0001 cnt=1",
                 k, q_w[k][0], flag_w[k], cnt_w[k], want[k]);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [3:0] sv[8] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
    logic       cv[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef SR_BANK_EDGE_EN
    logic [1:0] wc[8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    logic [3:0] wf[8] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
`else
    logic [1:0] wc[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0};
    logic [3:0] wf[8] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
`endif
    for (int t = 0; t < 8; t++) begin
      applyStimulus(sv[t], sv[t], cv[t], 1'b0);
      for (int k = 0; k < 5; k++) begin
        e = sb.pop_front();
        checks++;
        if ({q_w[k], qbar_w[k], flag_w[k], cnt_w[k]} !== {e.q, ~e.q, e.flag, e.cnt}) begin
          errors++;
          $display("[TB] FAIL saturation[%0d] dut%0d: got q=%h flag=%h cnt=%0d, need q=%h flag=%h cnt=%0d",
                   t, k, q_w[k], flag_w[k], cnt_w[k], e.q, e.flag, e.cnt);
        end
      end
      checks++;
      if ({flag_w[1], cnt_w[1]} !== {wf[t], wc[t]}) begin
        errors++;
        $display("[TB] FAIL saturation_literal[%0d]: got flag=%h cnt=%0d, need flag=%h cnt=%0d",
                 t, flag_w[1], cnt_w[1], wf[t], wc[t]);
      end
    end
  endtask

  task automatic test_toggle();
    exp_t e;
`ifdef SR_BANK_EDGE_EN
    logic want[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    logic want[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    for (int t = 0; t < 5; t++) begin
      if (t == 0) applyStimulus(4'b0000, 4'b0010, 1'b1, 1'b0);
      else        applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
        e = sb.pop_front();
        checks++;
        if ({q_w[k], qbar_w[k], flag_w[k], cnt_w[k]} !== {e.q, ~e.q, e.flag, e.cnt}) begin
          errors++;
          $display("[TB] FAIL toggle[%0d] dut%0d: got q=%h flag=%h cnt=%0d, need q=%h flag=%h cnt=%0d",
                   t, k, q_w[k], flag_w[k], cnt_w[k], e.q, e.flag, e.cnt);
        end
      end
      if (t > 0) begin
        checks++;
        if (q_w[3][1] !== want[t-1]) begin
          errors++;
          $display("[TB] FAIL toggle_literal[%0d]: got q1=%b, need %b", t, q_w[3][1], want[t-1]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic rv[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 4; t++) begin
      applyStimulus(4'hF, 4'h0, 1'b0, rv[t]);
      for (int k = 0; k < 5; k++) begin
        e = sb.pop_front();
        checks++;
        if ({q_w[k], qbar_w[k], flag_w[k], cnt_w[k]} !== {e.q, ~e.q, e.flag, e.cnt}) begin
          errors++;
          $display("[TB] FAIL mid_reset[%0d] dut%0d: got q=%h flag=%h cnt=%0d, need q=%h flag=%h cnt=%0d",
                   t, k, q_w[k], flag_w[k], cnt_w[k], e.q, e.flag, e.cnt);
        end
      end
      if (t == 2) begin
        checks++;
        if ({q_w[0], q_w[4], cnt_w[0], cnt_w[4]} !== {4'h0, 4'hA, 2'd0, 2'd0}) begin
          errors++;
          $display("[TB] FAIL mid_reset_literal: got q0=%h q4=%h cnt0=%0d cnt4=%0d, need 0 A 0 0",
                   q_w[0], q_w[4], cnt_w[0], cnt_w[4]);
        end
      end
      if (t == 3) begin
        checks++;
        if (q_w[1] !== 4'hF) begin
          errors++;
          $display("[TB] FAIL post_reset_literal: got q=%h, need F", q_w[1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0] sv, rv;
    logic clrv, rstv;
    for (int t = 0; t < 60; t++) begin
      sv = 4'($urandom_range(0, 15));
      rv = 4'($urandom_range(0, 15));
      clrv = ($urandom_range(0, 3) == 0);
      rstv = ($urandom_range(0, 15) == 0);
      applyStimulus(sv, rv, clrv, rstv);
      for (int k = 0; k < 5; k++) begin
        e = sb.pop_front();
        checks++;
        if ({q_w[k], qbar_w[k], flag_w[k], cnt_w[k]} !== {e.q, ~e.q, e.flag, e.cnt}) begin
          errors++;
          $display("[TB] FAIL back_to_back[%0d] dut%0d: got q=%h qbar=%h flag=%h cnt=%0d, need q=%h flag=%h cnt=%0d",
                   t, k, q_w[k], qbar_w[k], flag_w[k], cnt_w[k], e.q, e.flag, e.cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_reset();
    test_conflict_modes();
    test_saturation();
    test_toggle();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
